// File: rtl/ir_cam_sequencer.sv
// IR camera command sequencer: writes the init table, then polls the report
// over the byte-level I2C master and publishes blob 0 once per report.
module ir_cam_sequencer #(
   parameter logic [6:0]  I2C_ADDR       = 7'h58,
   parameter int unsigned POWERUP_CYCLES = 1000,
   parameter int unsigned GAP_CYCLES     = 64,
   parameter int unsigned POLL_CYCLES    = 10000,
   parameter int unsigned READ_BYTES     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       reset,
   output logic [6:0] i2c_addr,
   output logic       i2c_rw,
   output logic [4:0] i2c_packets,
   output logic       i2c_start,
   output logic [7:0] i2c_data,
   input  logic       i2c_ready,
   input  logic       i2c_data_req,
   input  logic       i2c_data_ready,
   input  logic [7:0] i2c_data_out,
   output logic [9:0] blob_x,
   output logic [9:0] blob_y,
   output logic [3:0] blob_size,
   output logic       blob_valid,
   output logic       frame_valid,
   output logic       init_done,
   output logic       timeout_err
);

   localparam int unsigned MAX_A   = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
   localparam int unsigned MAX_B   = (POLL_CYCLES > TIMEOUT_CYCLES) ? POLL_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned MAX_T   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned TMR_W   = $clog2(MAX_T + 1);
   localparam int unsigned ENTRIES = 6;

   typedef enum logic [3:0] {
      PWRUP, INIT_GO, INIT_WAIT, GAP, PTR_GO, PTR_WAIT, RD_GO, RD_WAIT, PUBLISH, POLL
   } state_t;

   state_t           state, state_n;
   logic [TMR_W-1:0] timer, timer_n;
   logic [2:0]       entry, entry_n;
   logic             idx, idx_n;
   logic             seen_low, seen_low_n;
   logic             dr_q;
   logic [4:0]       byte_cnt, byte_cnt_n;
   logic [7:0]       xl, xl_n, yl, yl_n, s, s_n;
   logic             rw_n, start_n, blob_valid_n, frame_valid_n, init_done_n, timeout_err_n;
   logic [4:0]       packets_n;
   logic [7:0]       data_n;
   logic [9:0]       blob_x_n, blob_y_n;
   logic [3:0]       blob_size_n;
   logic             rise_c;
   logic [7:0]       wr_byte_c;

   // Camera init table: two bytes (register, value) per entry
   function automatic logic [7:0] init_byte(input logic [2:0] e, input logic i);
      case ({e, i})
         4'b0000: init_byte = 8'h30;
         4'b0001: init_byte = 8'h01;
         4'b0010: init_byte = 8'h30;
         4'b0011: init_byte = 8'h08;
         4'b0100: init_byte = 8'h06;
         4'b0101: init_byte = 8'h90;
         4'b0110: init_byte = 8'h08;
         4'b0111: init_byte = 8'hC0;
         4'b1000: init_byte = 8'h1A;
         4'b1001: init_byte = 8'h40;
         4'b1010: init_byte = 8'h33;
         4'b1011: init_byte = 8'h33;
         default: init_byte = 8'h00;
      endcase
   endfunction

   assign i2c_addr  = I2C_ADDR;
   assign rise_c    = i2c_data_ready & ~dr_q;
   assign wr_byte_c = init_done ? 8'h36 : init_byte(entry, idx);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= PWRUP;
         timer       <= TMR_W'(POWERUP_CYCLES);
         entry       <= '0;
         idx         <= 1'b0;
         seen_low    <= 1'b0;
         dr_q        <= 1'b0;
         byte_cnt    <= '0;
         xl          <= '0;
         yl          <= '0;
         s           <= '0;
         i2c_rw      <= 1'b0;
         i2c_packets <= '0;
         i2c_start   <= 1'b0;
         i2c_data    <= '0;
         blob_x      <= '0;
         blob_y      <= '0;
         blob_size   <= '0;
         blob_valid  <= 1'b0;
         frame_valid <= 1'b0;
         init_done   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         timer       <= timer_n;
         entry       <= entry_n;
         idx         <= idx_n;
         seen_low    <= seen_low_n;
         dr_q        <= i2c_data_ready;
         byte_cnt    <= byte_cnt_n;
         xl          <= xl_n;
         yl          <= yl_n;
         s           <= s_n;
         i2c_rw      <= rw_n;
         i2c_packets <= packets_n;
         i2c_start   <= start_n;
         i2c_data    <= data_n;
         blob_x      <= blob_x_n;
         blob_y      <= blob_y_n;
         blob_size   <= blob_size_n;
         blob_valid  <= blob_valid_n;
         frame_valid <= frame_valid_n;
         init_done   <= init_done_n;
         timeout_err <= timeout_err_n;
      end
   end

   always_comb begin
      state_n       = state;
      timer_n       = timer;
      entry_n       = entry;
      idx_n         = idx;
      seen_low_n    = seen_low;
      byte_cnt_n    = byte_cnt;
      xl_n          = xl;
      yl_n          = yl;
      s_n           = s;
      rw_n          = i2c_rw;
      packets_n     = i2c_packets;
      start_n       = 1'b0;
      data_n        = i2c_data;
      blob_x_n      = blob_x;
      blob_y_n      = blob_y;
      blob_size_n   = blob_size;
      blob_valid_n  = blob_valid;
      frame_valid_n = 1'b0;
      init_done_n   = init_done;
      timeout_err_n = timeout_err;

      // Write-byte feed; idx saturates so a late request repeats the last byte
      if (i2c_data_req) begin
         data_n = wr_byte_c;
         if (!init_done) idx_n = 1'b1;
      end

      case (state)
         PWRUP: begin
            if (timer <= TMR_W'(1)) begin
               state_n = INIT_GO;
               entry_n = '0;
            end else begin
               timer_n = timer - TMR_W'(1);
            end
         end
         INIT_GO, PTR_GO, RD_GO: begin
            if (i2c_ready) begin
               start_n    = 1'b1;
               rw_n       = (state == RD_GO);
               packets_n  = (state == RD_GO) ? 5'(READ_BYTES) : (state == INIT_GO) ? 5'd2 : 5'd1;
               idx_n      = 1'b0;
               seen_low_n = 1'b0;
               timer_n    = '0;
               byte_cnt_n = '0;
               state_n    = (state == INIT_GO) ? INIT_WAIT : (state == PTR_GO) ? PTR_WAIT : RD_WAIT;
            end
         end
         INIT_WAIT, PTR_WAIT, RD_WAIT: begin
            timer_n = timer + TMR_W'(1);
            if (!i2c_ready) seen_low_n = 1'b1;
            if (state == RD_WAIT && rise_c) begin
               if (byte_cnt < 5'(READ_BYTES)) byte_cnt_n = byte_cnt + 5'd1;
               case (byte_cnt)
                  5'd1:    xl_n = i2c_data_out;
                  5'd2:    yl_n = i2c_data_out;
                  5'd3:    s_n  = i2c_data_out;
                  default: ;
               endcase
            end
            // Completion needs ready to have dropped first; otherwise watch the clock
            if (seen_low && i2c_ready) begin
               if (state == RD_WAIT) begin
                  state_n = PUBLISH;
               end else begin
                  state_n = GAP;
                  timer_n = TMR_W'(GAP_CYCLES);
                  if (state == INIT_WAIT) entry_n = entry + 3'd1;
               end
            end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_err_n = 1'b1;
               init_done_n   = 1'b0;
               state_n       = PWRUP;
               timer_n       = TMR_W'(POWERUP_CYCLES);
            end
         end
         GAP: begin
            if (timer <= TMR_W'(1)) begin
               if (init_done) begin
                  state_n = RD_GO;
               end else if (entry < 3'(ENTRIES)) begin
                  state_n = INIT_GO;
               end else begin
                  init_done_n = 1'b1;
                  state_n     = PTR_GO;
               end
            end else begin
               timer_n = timer - TMR_W'(1);
            end
         end
         PUBLISH: begin
            if (byte_cnt >= 5'd4) begin
               blob_x_n      = {s[5:4], xl};
               blob_y_n      = {s[7:6], yl};
               blob_size_n   = s[3:0];
               blob_valid_n  = ({s[7:6], yl} != 10'h3FF);
               frame_valid_n = 1'b1;
            end
            state_n = POLL;
            timer_n = TMR_W'(POLL_CYCLES);
         end
         POLL: begin
            if (timer <= TMR_W'(1)) state_n = PTR_GO;
            else                    timer_n = timer - TMR_W'(1);
         end
         default: state_n = PWRUP;
      endcase
   end

endmodule

// File: tb/tb_ir_cam_sequencer.sv
// Bench for ir_cam_sequencer: behavioural I2C master plus frame monitor,
// scenario tasks compare against values derived from the camera protocol.
module tb_ir_cam_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] i2c_addr;
   logic       i2c_rw;
   logic [4:0] i2c_packets;
   logic       i2c_start;
   logic [7:0] i2c_data;
   logic       i2c_ready;
   logic       i2c_data_req;
   logic       i2c_data_ready;
   logic [7:0] i2c_data_out;
   logic [9:0] blob_x, blob_y;
   logic [3:0] blob_size;
   logic       blob_valid, frame_valid, init_done, timeout_err;

   always #5 clk = ~clk;

   ir_cam_sequencer dut (
      .clk(clk), .reset(reset),
      .i2c_addr(i2c_addr), .i2c_rw(i2c_rw), .i2c_packets(i2c_packets),
      .i2c_start(i2c_start), .i2c_data(i2c_data), .i2c_ready(i2c_ready),
      .i2c_data_req(i2c_data_req), .i2c_data_ready(i2c_data_ready),
      .i2c_data_out(i2c_data_out),
      .blob_x(blob_x), .blob_y(blob_y), .blob_size(blob_size),
      .blob_valid(blob_valid), .frame_valid(frame_valid),
      .init_done(init_done), .timeout_err(timeout_err)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int rel_cyc = 0;

   logic [7:0] init_tbl [12] = '{8'h30, 8'h01, 8'h30, 8'h08, 8'h06, 8'h90,
                                 8'h08, 8'hC0, 8'h1A, 8'h40, 8'h33, 8'h33};

   // Transaction log filled by the master model
   int         txn_n = 0;
   logic       t_rw [64];
   int         t_pk [64];
   logic [7:0] t_b [64][2];
   int         t_start [64];
   int         t_done [64];

   logic [7:0] rd_bytes [32];
   int         rd_n = 16;
   int         hang_at = -1;
   bit         release_hang = 1'b0;
   int         m_rdcnt = 0;

   // Frame log filled by the monitor
   int         fr_n = 0;
   logic [9:0] fr_x [32];
   logic [9:0] fr_y [32];
   logic [3:0] fr_s [32];
   logic       fr_v [32];
   int         fr_cyc [32];
   int         dbl = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Behavioural I2C master: takes start, feeds write bytes / read bytes, returns ready
   initial begin
      bit m_busy;
      bit m_hang;
      int m_cnt;
      int cur;
      int end_cnt;
      m_busy = 0; m_hang = 0; m_cnt = 0; cur = 0;
      i2c_ready = 1'b1; i2c_data_req = 1'b0; i2c_data_ready = 1'b0; i2c_data_out = 8'h00;
      forever begin
         @(negedge clk);
         i2c_data_req = 1'b0;
         if (reset) begin
            m_busy = 0; i2c_ready = 1'b1; i2c_data_ready = 1'b0;
         end else if (!m_busy) begin
            if (i2c_start) begin
               cur = txn_n;
               t_rw[cur] = i2c_rw; t_pk[cur] = int'(i2c_packets);
               t_start[cur] = cyc; t_done[cur] = -1;
               t_b[cur][0] = 8'h00; t_b[cur][1] = 8'h00;
               m_hang = (cur == hang_at);
               txn_n++; m_busy = 1; m_cnt = 0; m_rdcnt = 0; i2c_ready = 1'b0;
            end
         end else begin
            m_cnt++;
            if (m_hang) begin
               if (release_hang) begin m_busy = 0; i2c_ready = 1'b1; end
            end else if (!t_rw[cur]) begin
               for (int j = 0; j < t_pk[cur]; j++) begin
                  if (m_cnt == 5 + 8*j) i2c_data_req = 1'b1;
                  if (m_cnt == 6 + 8*j && j < 2) t_b[cur][j] = i2c_data;
               end
               end_cnt = (8*t_pk[cur] + 12 > 40) ? 8*t_pk[cur] + 12 : 40;
               if (m_cnt >= end_cnt) begin m_busy = 0; i2c_ready = 1'b1; t_done[cur] = cyc; end
            end else begin
               for (int j = 0; j < rd_n; j++) begin
                  if (m_cnt == 5 + 8*j) begin
                     i2c_data_out = rd_bytes[j]; i2c_data_ready = 1'b1; m_rdcnt = j + 1;
                  end
                  if (m_cnt == 9 + 8*j) i2c_data_ready = 1'b0;
               end
               end_cnt = (8*rd_n + 12 > 40) ? 8*rd_n + 12 : 40;
               if (m_cnt >= end_cnt) begin m_busy = 0; i2c_ready = 1'b1; t_done[cur] = cyc; end
            end
         end
      end
   end

   initial begin
      bit fv_prev;
      fv_prev = 0;
      forever begin
         @(negedge clk);
         if (frame_valid) begin
            if (fv_prev) dbl++;
            fr_x[fr_n] = blob_x; fr_y[fr_n] = blob_y; fr_s[fr_n] = blob_size;
            fr_v[fr_n] = blob_valid; fr_cyc[fr_n] = cyc;
            fr_n++;
         end
         fv_prev = frame_valid;
      end
   end

   // Reference decode of blob 0 from report bytes 1..3
   function automatic int ref_x(input int b1, input int b3);
      return b1 + 256 * ((b3 / 16) % 4);
   endfunction
   function automatic int ref_y(input int b2, input int b3);
      return b2 + 256 * ((b3 / 64) % 4);
   endfunction

   task automatic wait_txn(input int n, input int budget, input string nm);
      int k = 0;
      while (txn_n < n && k < budget) begin @(posedge clk); #1; k++; end
      if (txn_n < n) begin
         tests++; fails++;
         $display("FAIL %s: transactions seen %0d, required %0d", nm, txn_n, n);
      end
   endtask

   task automatic wait_done(input int i, input int budget, input string nm);
      int k = 0;
      while (t_done[i] < 0 && k < budget) begin @(posedge clk); #1; k++; end
      if (t_done[i] < 0) begin
         tests++; fails++;
         $display("FAIL %s: transaction %0d never completed", nm, i);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      tests++;
      if (i2c_addr !== 7'h58) begin fails++; $display("FAIL reset_addr: got %h, want 58", i2c_addr); end
      tests++;
      if ({i2c_rw, i2c_packets, i2c_start, i2c_data} !== 15'd0) begin
         fails++; $display("FAIL reset_i2c: rw=%b pk=%0d st=%b d=%h, want all 0", i2c_rw, i2c_packets, i2c_start, i2c_data);
      end
      tests++;
      if ({blob_x, blob_y, blob_size, blob_valid, frame_valid, init_done, timeout_err} !== 28'd0) begin
         fails++; $display("FAIL reset_out: x=%h y=%h s=%h v=%b fv=%b id=%b te=%b, want all 0",
                           blob_x, blob_y, blob_size, blob_valid, frame_valid, init_done, timeout_err);
      end
      reset = 1'b0;
      rel_cyc = cyc;
   endtask

   task automatic test_init(input int base, input int rel, input string nm);
      int k, d;
      wait_txn(base + 6, 3000, {nm, "_starts"});
      wait_done(base + 5, 300, {nm, "_last"});
      tests++;
      if (t_start[base] - rel < 1000) begin
         fails++; $display("FAIL %s_powerup: first start after %0d cycles, want >= 1000", nm, t_start[base] - rel);
      end
      for (int i = 0; i < 6; i++) begin
         tests++;
         if (t_rw[base+i] !== 1'b0 || t_pk[base+i] != 2 ||
             t_b[base+i][0] !== init_tbl[2*i] || t_b[base+i][1] !== init_tbl[2*i+1]) begin
            fails++;
            $display("FAIL %s_entry%0d: rw=%b pk=%0d bytes %h %h, want rw=0 pk=2 bytes %h %h", nm, i,
                     t_rw[base+i], t_pk[base+i], t_b[base+i][0], t_b[base+i][1], init_tbl[2*i], init_tbl[2*i+1]);
         end
      end
      for (int i = 1; i < 6; i++) begin
         tests++;
         if (t_start[base+i] - t_done[base+i-1] < 64) begin
            fails++; $display("FAIL %s_gap%0d: gap %0d, want >= 64", nm, i, t_start[base+i] - t_done[base+i-1]);
         end
      end
      k = 0;
      while (!init_done && k < 200) begin @(posedge clk); #1; k++; end
      d = cyc - t_done[base+5];
      tests++;
      if (init_done !== 1'b1 || d < 64 || d > 70) begin
         fails++; $display("FAIL %s_done: init_done=%b after %0d cycles, want 1 after 64..70", nm, init_done, d);
      end
   endtask

   task automatic test_frame(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
      int tx0, n0, k, ex, ey;
      tx0 = txn_n; n0 = fr_n;
      rd_bytes[0] = b0; rd_bytes[1] = b1; rd_bytes[2] = b2; rd_bytes[3] = b3;
      for (int j = 4; j < 32; j++) rd_bytes[j] = 8'($urandom);
      wait_txn(tx0 + 2, 12000, {nm, "_txns"});
      tests++;
      if (t_rw[tx0] !== 1'b0 || t_pk[tx0] != 1 || t_b[tx0][0] !== 8'h36) begin
         fails++; $display("FAIL %s_ptr: rw=%b pk=%0d byte=%h, want 0 1 36", nm, t_rw[tx0], t_pk[tx0], t_b[tx0][0]);
      end
      tests++;
      if (t_rw[tx0+1] !== 1'b1 || t_pk[tx0+1] != 16 || t_start[tx0+1] - t_done[tx0] < 64) begin
         fails++; $display("FAIL %s_read: rw=%b pk=%0d gap=%0d, want 1 16 >=64", nm,
                           t_rw[tx0+1], t_pk[tx0+1], t_start[tx0+1] - t_done[tx0]);
      end
      k = 0;
      while (fr_n <= n0 && k < 1000) begin @(posedge clk); #1; k++; end
      ex = ref_x(int'(b1), int'(b3));
      ey = ref_y(int'(b2), int'(b3));
      tests++;
      if (fr_n != n0 + 1) begin
         fails++; $display("FAIL %s_strobe: frames %0d, want %0d", nm, fr_n, n0 + 1);
      end else begin
         if (fr_x[n0] !== 10'(ex) || fr_y[n0] !== 10'(ey) || fr_s[n0] !== 4'(int'(b3) % 16) ||
             fr_v[n0] !== (ey != 1023) || fr_cyc[n0] - t_done[tx0+1] < 1 || fr_cyc[n0] - t_done[tx0+1] > 4) begin
            fails++;
            $display("FAIL %s_blob: x=%h y=%h s=%h v=%b lat=%0d, want x=%h y=%h s=%h v=%b lat 1..4", nm,
                     fr_x[n0], fr_y[n0], fr_s[n0], fr_v[n0], fr_cyc[n0] - t_done[tx0+1],
                     10'(ex), 10'(ey), 4'(int'(b3) % 16), (ey != 1023));
         end
      end
      repeat (20) @(posedge clk);
      #1;
      tests++;
      if (frame_valid !== 1'b0 || blob_x !== 10'(ex) || blob_y !== 10'(ey)) begin
         fails++; $display("FAIL %s_hold: fv=%b x=%h y=%h, want 0 %h %h", nm, frame_valid, blob_x, blob_y, 10'(ex), 10'(ey));
      end
   endtask

   task automatic test_short_read;
      int tx0, n0;
      logic [9:0] px, py;
      logic [3:0] ps;
      tx0 = txn_n; n0 = fr_n; px = blob_x; py = blob_y; ps = blob_size;
      rd_n = 3;
      for (int j = 0; j < 32; j++) rd_bytes[j] = 8'($urandom);
      wait_txn(tx0 + 2, 12000, "short_txns");
      wait_done(tx0 + 1, 400, "short_read");
      repeat (10) @(posedge clk);
      #1;
      tests++;
      if (fr_n != n0) begin fails++; $display("FAIL short_strobe: frames %0d, want %0d", fr_n, n0); end
      tests++;
      if (blob_x !== px || blob_y !== py || blob_size !== ps) begin
         fails++; $display("FAIL short_hold: x=%h y=%h s=%h, want %h %h %h", blob_x, blob_y, blob_size, px, py, ps);
      end
      rd_n = 16;
   endtask

   task automatic test_reset_mid_read;
      int tx0, n0, k, base;
      tx0 = txn_n;
      rd_bytes[0] = 8'hFF; rd_bytes[1] = 8'h11; rd_bytes[2] = 8'h22; rd_bytes[3] = 8'h33;
      wait_txn(tx0 + 2, 12000, "midrd_txns");
      k = 0;
      while (m_rdcnt < 2 && k < 200) begin @(posedge clk); #1; k++; end
      reset = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if ({blob_x, blob_y, blob_size, blob_valid, frame_valid, init_done, timeout_err,
           i2c_rw, i2c_packets, i2c_start, i2c_data} !== 43'd0) begin
         fails++; $display("FAIL midrd_reset: x=%h y=%h s=%h v=%b id=%b st=%b pk=%0d, want all 0",
                           blob_x, blob_y, blob_size, blob_valid, init_done, i2c_start, i2c_packets);
      end
      rd_bytes[1] = 8'h44; rd_bytes[2] = 8'h55; rd_bytes[3] = 8'h66;
      base = txn_n; n0 = fr_n;
      reset = 1'b0;
      test_init(base, cyc, "reinit");
      tests++;
      if (fr_n != n0) begin fails++; $display("FAIL midrd_stale: frames %0d, want %0d", fr_n, n0); end
      test_frame("after_reset", 8'hFF, 8'h44, 8'h55, 8'h66);
   endtask

   task automatic test_timeout;
      int base, k, s, te;
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      base = txn_n; hang_at = base + 2; release_hang = 1'b0;
      reset = 1'b0;
      wait_txn(base + 3, 3000, "to_hang_start");
      s = t_start[base+2];
      k = 0;
      while (!timeout_err && k < 5000) begin @(posedge clk); #1; k++; end
      te = cyc;
      tests++;
      if (timeout_err !== 1'b1 || te - s != 4096) begin
         fails++; $display("FAIL to_time: timeout_err=%b after %0d cycles, want 1 after 4096", timeout_err, te - s);
      end
      tests++;
      if (init_done !== 1'b0) begin fails++; $display("FAIL to_init_done: got %b, want 0", init_done); end
      release_hang = 1'b1;
      wait_txn(base + 4, 1500, "to_restart");
      wait_done(base + 3, 300, "to_restart_done");
      tests++;
      if (t_start[base+3] - te < 1000) begin
         fails++; $display("FAIL to_powerup: restart after %0d cycles, want >= 1000", t_start[base+3] - te);
      end
      tests++;
      if (t_rw[base+3] !== 1'b0 || t_pk[base+3] != 2 || t_b[base+3][0] !== 8'h30 || t_b[base+3][1] !== 8'h01) begin
         fails++; $display("FAIL to_first_entry: rw=%b pk=%0d bytes %h %h, want 0 2 30 01",
                           t_rw[base+3], t_pk[base+3], t_b[base+3][0], t_b[base+3][1]);
      end
      tests++;
      if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b, want 1", timeout_err); end
      hang_at = -1; release_hang = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) t_done[i] = -1;
      for (int j = 0; j < 32; j++) rd_bytes[j] = 8'hFF;
      test_reset;
      test_init(0, rel_cyc, "init");
      test_frame("basic", 8'hFF, 8'h2A, 8'h7B, 8'h96);
      test_frame("all_ff", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      test_frame("random_a", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      test_frame("random_b", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      test_short_read;
      test_reset_mid_read;
      test_timeout;
      tests++;
      if (dbl != 0) begin fails++; $display("FAIL strobe_width: %0d multi-cycle strobes, want 0", dbl); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ir_cam_sequencer.md
Name: ir_cam_sequencer

Overview:
- Command sequencer sitting directly upstream of the byte-level I2C master. It drives that master's request interface and consumes its read data.
- After power-up it writes the six-register IR camera init table. It then repeatedly sets the read pointer and burst-reads the report.
- From each report it decodes blob 0 into X/Y/size for the drawing pipeline, and publishes one frame strobe per report.

Parameters:
- I2C_ADDR, 7'h58: camera 7-bit address.
- POWERUP_CYCLES, 1000: clk cycles idle after reset before the first transaction.
- GAP_CYCLES, 64: bus-free clk cycles after each transaction completes.
- POLL_CYCLES, 10000: clk cycles between report reads (measured from PUBLISH).
- READ_BYTES, 16: bytes per report burst; legal range 4..31.
- TIMEOUT_CYCLES, 4096: max clk cycles waiting for a transaction to complete.

Ports:
- clk  in  1  system clock; also the I2C master's clock.
- reset  in  1  synchronous, active-high.
- i2c_addr  out  7  constant I2C_ADDR.
- i2c_rw  out  1  1 = read, 0 = write; valid while i2c_start is high.
- i2c_packets  out  5  data byte count; valid while i2c_start is high.
- i2c_start  out  1  one-cycle transaction request.
- i2c_data  out  8  write byte presented to the master.
- i2c_ready  in  1  master idle/stopping.
- i2c_data_req  in  1  one-cycle request for the next write byte.
- i2c_data_ready  in  1  level flag; a rising edge means i2c_data_out holds a new byte.
- i2c_data_out  in  8  read byte.
- blob_x  out  10  blob 0 X coordinate.
- blob_y  out  10  blob 0 Y coordinate.
- blob_size  out  4  blob 0 size.
- blob_valid  out  1  1 when blob_y != 10'h3FF.
- frame_valid  out  1  one-cycle strobe on each blob update.
- init_done  out  1  high once the init table has been written.
- timeout_err  out  1  sticky; cleared only by reset.

Behaviour:
- Reset values: all outputs 0, except i2c_addr = I2C_ADDR and i2c_rw = 0. The timer is loaded with POWERUP_CYCLES and the state is PWRUP. Reset mid-transaction abandons it; no stop is issued.
- Init table, written in order, each entry as one 2-byte write transaction: {30,01} {30,08} {06,90} {08,C0} {1A,40} {33,33}.
- Pointer write: 1-byte write {36}.
- Read: rw = 1, packets = READ_BYTES.
- Write data handshake:
  - idx is cleared at each start.
  - On a cycle with i2c_data_req = 1: i2c_data <= byte[idx] and idx <= idx + 1. The master samples i2c_data on the cycle after req.
  - A data_req after the last byte re-presents the last byte.
- Start handshake:
  - i2c_start is asserted for exactly 1 cycle, only when i2c_ready = 1. It then stays low until completion.
  - Completion = i2c_ready seen low and then high again. A ready that stays high does not count as completion.
- Timeout: the wait timer counts from start. On reaching TIMEOUT_CYCLES: set timeout_err, clear init_done, go to PWRUP (the init table restarts).
- State machine:
  - PWRUP: count down, then go to INIT_GO with entry = 0.
  - INIT_GO: issue start for the current entry, then INIT_WAIT.
  - INIT_WAIT: on completion go to GAP; entry increments.
  - GAP: count GAP_CYCLES, then leave:
    - to INIT_GO if entry < 6;
    - otherwise set init_done and go to PTR_GO (or follow the read-flow path below).
  - PTR_GO, then PTR_WAIT, then GAP, then RD_GO.
  - RD_GO, then RD_WAIT, then PUBLISH, then POLL (count POLL_CYCLES), then PTR_GO.
- Read capture:
  - The rising edge is detected on a registered copy of i2c_data_ready. byte_cnt increments per edge, saturating at READ_BYTES.
  - Byte 0 is discarded. Bytes 1, 2, 3 are latched as xl, yl, s.
  - Only edges seen during RD_WAIT count.
- PUBLISH (1 cycle), only if byte_cnt >= 4:
  - blob_x = {s[5:4], xl}, blob_y = {s[7:6], yl}, blob_size = s[3:0].
  - blob_valid = (blob_y != 10'h3FF); frame_valid = 1 for that cycle.
  - If byte_cnt < 4, blob outputs are held and there is no strobe.
- Outputs hold between frames.

Test Plan:
- Reset, then a master model that responds after 40 cycles → no start before 1000 cycles. Exactly 6 write transactions with i2c_packets = 2, bytes 30 01, 30 08, 06 90, 08 C0, 1A 40, 33 33. init_done rises after the 6th completion plus the gap.
- After init → 1-byte write of 36, then a read with i2c_packets = 16 and i2c_rw = 1. Starts are spaced at least 64 cycles after each ready return.
- Read bytes FF, 2A, 7B, 96 → blob_x = 0x12A, blob_y = 0x27B, blob_size = 6, blob_valid = 1, with a 1-cycle frame_valid.
- Read bytes FF, FF, FF, FF → blob_x = 0x3FF, blob_y = 0x3FF, blob_valid = 0, frame_valid still pulses.
- Master never returns ready during the 3rd init write → timeout_err = 1 at start + 4096 cycles, init_done = 0, then the init table restarts from {30,01} after 1000 cycles.
- Assert reset during RD_WAIT after 2 bytes → all outputs 0 the next cycle; the full init sequence re-runs; stale bytes are never published.
